// File: rtl/pin_lock_if.sv
// Handshake bundle between the card/PIN front end (master) and the lock controller (slave).
interface pin_lock_if;
   logic       session_start;
   logic       session_end;
   logic       pin_valid;
   logic       pin_ok;
   logic       time_up;
   logic       start_timer;
   logic       access_grant;
   logic       locked;
   logic       blocked;
   logic [2:0] attempts_left;
   logic [7:0] lock_count;
   logic [2:0] state_o;

   modport master (
      output session_start, session_end, pin_valid, pin_ok, time_up,
      input  start_timer, access_grant, locked, blocked, attempts_left, lock_count, state_o
   );

   modport slave (
      input  session_start, session_end, pin_valid, pin_ok, time_up,
      output start_timer, access_grant, locked, blocked, attempts_left, lock_count, state_o
   );
endinterface

// File: rtl/pin_lock_ctrl.sv
// PIN entry lockout controller: limits wrong PINs per lockout window and blocks
// permanently after LOCK_LIMIT lockouts. Every output comes straight from a flop.
module pin_lock_ctrl #(
   parameter int MAX_ATTEMPTS = 3,
   parameter int LOCK_LIMIT   = 2
) (
   input  logic       clk,
   input  logic       rst,
   pin_lock_if.slave  bus
);

   localparam logic [2:0] MAX_A = 3'(MAX_ATTEMPTS);
   localparam logic [7:0] LIM   = 8'(LOCK_LIMIT);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ACTIVE   = 3'd1,
      GRANTED  = 3'd2,
      LOCKED   = 3'd3,
      COOLDOWN = 3'd4,
      BLOCKED  = 3'd5
   } state_t;

   state_t     state_q, state_n;
   logic [2:0] att_q, att_n;
   logic [7:0] lcnt_q, lcnt_n;
   logic       grant_q, grant_n;
   logic       timer_q, locked_q, blocked_q;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_n = state_q;
      att_n   = att_q;
      lcnt_n  = lcnt_q;
      grant_n = 1'b0;
      case (state_q)
         IDLE: if (bus.session_start) state_n = ACTIVE;
         ACTIVE: begin
            // session_end wins so a PIN strobe racing card removal is discarded
            if (bus.session_end) begin
               state_n = IDLE;
            end else if (bus.pin_valid) begin
               if (bus.pin_ok) begin
                  state_n = GRANTED;
                  att_n   = MAX_A;
                  grant_n = 1'b1;
               end else if (att_q > 3'd1) begin
                  att_n = att_q - 3'd1;
               end else begin
                  att_n   = 3'd0;
                  lcnt_n  = sat_inc(lcnt_q);
                  state_n = (lcnt_n == LIM) ? BLOCKED : LOCKED;
               end
            end
         end
         GRANTED:  if (bus.session_end) state_n = IDLE;
         LOCKED:   if (bus.time_up) state_n = COOLDOWN;
         COOLDOWN: begin
            att_n   = MAX_A;
            state_n = IDLE;
         end
         BLOCKED:  state_n = BLOCKED;
         default:  state_n = IDLE;
      endcase
   end

   // Timer/lock flags are registered from the next state so they line up with state_o
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         att_q     <= MAX_A;
         lcnt_q    <= 8'd0;
         grant_q   <= 1'b0;
         timer_q   <= 1'b0;
         locked_q  <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         att_q     <= att_n;
         lcnt_q    <= lcnt_n;
         grant_q   <= grant_n;
         timer_q   <= (state_n == LOCKED);
         locked_q  <= (state_n == LOCKED) || (state_n == BLOCKED);
         blocked_q <= (state_n == BLOCKED);
      end
   end

   assign bus.state_o       = state_q;
   assign bus.attempts_left = att_q;
   assign bus.lock_count    = lcnt_q;
   assign bus.access_grant  = grant_q;
   assign bus.start_timer   = timer_q;
   assign bus.locked        = locked_q;
   assign bus.blocked       = blocked_q;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Directed bench for pin_lock_ctrl with default parameters (3 attempts, 2 lockouts).
module tb_pin_lock_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   pin_lock_if bus ();

   pin_lock_ctrl #(.MAX_ATTEMPTS(3), .LOCK_LIMIT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input logic ok);
      bus.pin_valid = 1'b1;
      bus.pin_ok    = ok;
      cyc();
      bus.pin_valid = 1'b0;
      bus.pin_ok    = 1'b0;
   endtask

   task automatic start();
      bus.session_start = 1'b1;
      cyc();
      bus.session_start = 1'b0;
   endtask

   task automatic stop();
      bus.session_end = 1'b1;
      cyc();
      bus.session_end = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"},  32'(bus.state_o), 0);
      chk({tag, "_att"},    32'(bus.attempts_left), 3);
      chk({tag, "_lcnt"},   32'(bus.lock_count), 0);
      chk({tag, "_timer"},  32'(bus.start_timer), 0);
      chk({tag, "_grant"},  32'(bus.access_grant), 0);
      chk({tag, "_locked"}, 32'(bus.locked), 0);
      chk({tag, "_blk"},    32'(bus.blocked), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.session_start = 1'b0;
      bus.session_end   = 1'b0;
      bus.pin_valid     = 1'b0;
      bus.pin_ok        = 1'b0;
      bus.time_up       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      rst = 1'b0;

      // correct PIN on defaults
      start();
      chk("act_state", 32'(bus.state_o), 1);
      pin(1'b1);
      chk("grant_state", 32'(bus.state_o), 2);
      chk("grant_pulse", 32'(bus.access_grant), 1);
      chk("grant_att", 32'(bus.attempts_left), 3);
      cyc();
      chk("grant_once", 32'(bus.access_grant), 0);
      chk("grant_hold", 32'(bus.state_o), 2);
      stop();
      chk("grant_end", 32'(bus.state_o), 0);

      // evasion attempt: wrong count survives session boundaries
      start();
      pin(1'b0);
      chk("ev_att2", 32'(bus.attempts_left), 2);
      pin(1'b0);
      chk("ev_att1", 32'(bus.attempts_left), 1);
      stop();
      chk("ev_idle", 32'(bus.state_o), 0);
      chk("ev_keep", 32'(bus.attempts_left), 1);
      start();
      chk("ev_act", 32'(bus.state_o), 1);
      chk("ev_keep2", 32'(bus.attempts_left), 1);

      // session_end and wrong PIN in the same cycle
      bus.session_end = 1'b1;
      pin(1'b0);
      bus.session_end = 1'b0;
      chk("same_state", 32'(bus.state_o), 0);
      chk("same_att", 32'(bus.attempts_left), 1);
      start();
      pin(1'b0);
      chk("lk_state", 32'(bus.state_o), 3);
      chk("lk_att", 32'(bus.attempts_left), 0);
      chk("lk_lcnt", 32'(bus.lock_count), 1);
      chk("lk_timer", 32'(bus.start_timer), 1);
      chk("lk_locked", 32'(bus.locked), 1);
      chk("lk_blk", 32'(bus.blocked), 0);
      bus.session_start = 1'b1;
      bus.pin_valid     = 1'b1;
      bus.pin_ok        = 1'b1;
      cyc();
      bus.session_start = 1'b0;
      bus.pin_valid     = 1'b0;
      bus.pin_ok        = 1'b0;
      chk("lk_ignore", 32'(bus.state_o), 3);
      chk("lk_nogrant", 32'(bus.access_grant), 0);
      chk("lk_timer2", 32'(bus.start_timer), 1);

      // timer expiry -> one cooldown cycle -> idle with fresh attempts
      bus.time_up = 1'b1;
      cyc();
      bus.time_up = 1'b0;
      chk("cd_state", 32'(bus.state_o), 4);
      chk("cd_timer", 32'(bus.start_timer), 0);
      chk("cd_locked", 32'(bus.locked), 0);
      cyc();
      chk("cd_idle", 32'(bus.state_o), 0);
      chk("cd_att", 32'(bus.attempts_left), 3);

      // time_up ignored in IDLE
      bus.time_up = 1'b1;
      cyc();
      bus.time_up = 1'b0;
      chk("tu_idle", 32'(bus.state_o), 0);

      // second lockout reaches LOCK_LIMIT -> BLOCKED
      start();
      pin(1'b0);
      chk("b_att2", 32'(bus.attempts_left), 2);
      pin(1'b0);
      chk("b_att1", 32'(bus.attempts_left), 1);
      pin(1'b0);
      chk("b_att0", 32'(bus.attempts_left), 0);
      chk("b_lcnt", 32'(bus.lock_count), 2);
      chk("b_state", 32'(bus.state_o), 5);
      chk("b_blk", 32'(bus.blocked), 1);
      chk("b_locked", 32'(bus.locked), 1);
      chk("b_timer", 32'(bus.start_timer), 0);
      bus.time_up       = 1'b1;
      bus.session_start = 1'b1;
      cyc();
      cyc();
      bus.time_up       = 1'b0;
      bus.session_start = 1'b0;
      chk("b_hold", 32'(bus.state_o), 5);
      chk("b_hold_blk", 32'(bus.blocked), 1);

      // asynchronous reset out of BLOCKED, checked before any edge
      #2 rst = 1'b1;
      #1;
      chk_reset("arst_blk");
      rst = 1'b0;

      // drive into LOCKED, then async reset mid-cycle
      start();
      chk("post_act", 32'(bus.state_o), 1);
      pin(1'b0);
      pin(1'b0);
      pin(1'b0);
      chk("r_lk_state", 32'(bus.state_o), 3);
      chk("r_lk_lcnt", 32'(bus.lock_count), 1);
      #2 rst = 1'b1;
      #1;
      chk_reset("arst_lk");
      #1 rst = 1'b0;
      start();
      chk("r_first", 32'(bus.state_o), 1);
      pin(1'b1);
      chk("r_grant", 32'(bus.access_grant), 1);
      chk("r_gstate", 32'(bus.state_o), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
